// File: rtl/lbm_pkg.sv
// Shared definitions for the LBM collide/sweep datapath: Q3.13 word format,
// D2Q9 direction packing and the sweep sequencer state encoding.
package lbm_pkg;

    // Q3.13 fixed point word
    localparam int FRAC_BITS = 13;
    localparam int WORD_W    = 16;

    // D2Q9 distributions, packed {nw,w,sw,s,se,e,ne,n,null} MSB first,
    // so direction d occupies bits [d*WORD_W +: WORD_W].
    localparam int DIR_COUNT = 9;
    localparam int F_W       = DIR_COUNT * WORD_W;

    localparam int DIR_NULL = 0;
    localparam int DIR_N    = 1;
    localparam int DIR_NE   = 2;
    localparam int DIR_E    = 3;
    localparam int DIR_SE   = 4;
    localparam int DIR_S    = 5;
    localparam int DIR_SW   = 6;
    localparam int DIR_W    = 7;
    localparam int DIR_NW   = 8;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        SYNC,
        DONE
    } sweep_state_e;

    // Extract one direction word from a packed distribution vector.
    function automatic logic [WORD_W-1:0] dir_word(input logic [F_W-1:0] f,
                                                   input int unsigned   dir);
        return f[dir*WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/collide_pipe_regs.sv
// Stage-1/stage-2 pipeline registers between lattice read and write-back.
// Stage 1 carries the address of the cell whose distributions are on rd_data;
// stage 2 carries the address and the registered collider result to write.
// Nothing advances while hold is high.
module collide_pipe_regs
    import lbm_pkg::*;
#(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              s0_vld_i,
    input  logic [ADDR_W-1:0] s0_addr_i,
    input  logic [F_W-1:0]    f_new_i,
    output logic              s1_vld_o,
    output logic              s2_vld_o,
    output logic [ADDR_W-1:0] s2_addr_o,
    output logic [F_W-1:0]    s2_data_o
);

    logic              s1_vld_q;
    logic [ADDR_W-1:0] s1_addr_q;
    logic              s2_vld_q;
    logic [ADDR_W-1:0] s2_addr_q;
    logic [F_W-1:0]    s2_data_q;

    // Advance both stages together unless frozen; payload only loads on valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s1_addr_q <= '0;
            s2_vld_q  <= 1'b0;
            s2_addr_q <= '0;
            // NOTE: this data register is reset (unlike a RAM) because it
            // drives wr_data directly and the port must read 0 in reset.
            s2_data_q <= '0;
        end else if (!hold) begin
            // NOTE: non-blocking assignments let every stage sample the
            // pre-edge value of the stage before it.
            s1_vld_q <= s0_vld_i;
            s2_vld_q <= s1_vld_q;
            if (s0_vld_i) begin
                s1_addr_q <= s0_addr_i;
            end
            if (s1_vld_q) begin
                s2_addr_q <= s1_addr_q;
                s2_data_q <= f_new_i;
            end
        end
    end

    assign s1_vld_o  = s1_vld_q;
    assign s2_vld_o  = s2_vld_q;
    assign s2_addr_o = s2_addr_q;
    assign s2_data_o = s2_data_q;

endmodule

// File: rtl/collide_sweep_ctrl.sv
// Collide sweep sequencer: streams every lattice cell through the
// combinational collider (read, collide, write back in place, one cell per
// cycle), then hands off to the streaming engine and repeats for num_steps.
// Optional macro COLLIDE_MASS_MON_EN adds the mass_sum rho accumulator.
module collide_sweep_ctrl
    import lbm_pkg::*;
#(
    parameter int GRID_W = 64,
    parameter int GRID_H = 32,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       num_steps,
    input  logic [WORD_W-1:0] omega_in,
    input  logic              hold,
    output logic              sweep_done,
    input  logic              ext_ack,
    output logic              busy,
    output logic              done,
    output logic [15:0]       step_cnt,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [F_W-1:0]    rd_data,
    output logic [F_W-1:0]    col_f,
    output logic [WORD_W-1:0] col_omega,
    input  logic [F_W-1:0]    col_f_new,
    input  logic [WORD_W-1:0] col_rho,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
`ifdef COLLIDE_MASS_MON_EN
    output logic [31:0]       mass_sum,
`endif
    output logic [F_W-1:0]    wr_data
);

    localparam int                N_CELLS   = GRID_W * GRID_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_CELLS - 1);

    sweep_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       step_q, step_d;
    logic [15:0]       nsteps_q, nsteps_d;
    logic [WORD_W-1:0] omega_q, omega_d;

    logic              s1_vld;
    logic              s2_vld;
    logic [ADDR_W-1:0] s2_addr;
    logic [F_W-1:0]    s2_data;

    // Sequencer state, cell address, step counter and latched run settings.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            step_q   <= '0;
            nsteps_q <= '0;
            omega_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            step_q   <= step_d;
            nsteps_q <= nsteps_d;
            omega_q  <= omega_d;
        end
    end

    // Next-state and strobe logic; hold freezes the sweep in RUN and DRAIN.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        state_d    = state_q;
        addr_d     = addr_q;
        step_d     = step_q;
        nsteps_d   = nsteps_q;
        omega_d    = omega_q;
        rd_en      = 1'b0;
        sweep_done = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    nsteps_d = num_steps;
                    omega_d  = omega_in;
                    step_d   = '0;
                    if (num_steps == 16'd0) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                        addr_d  = '0;
                    end
                end
            end
            RUN: begin
                if (!hold) begin
                    rd_en = 1'b1;
                    if (addr_q == LAST_ADDR) begin
                        state_d = DRAIN;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (!hold && s2_vld && (s2_addr == LAST_ADDR)) begin
                    sweep_done = 1'b1;
                    step_d     = (step_q == 16'hFFFF) ? step_q : step_q + 16'd1;
                    state_d    = SYNC;
                end
            end
            SYNC: begin
                if (ext_ack) begin
                    if (step_q == nsteps_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                        addr_d  = '0;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    collide_pipe_regs #(
        .ADDR_W (ADDR_W)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .hold      (hold),
        .s0_vld_i  (rd_en),
        .s0_addr_i (addr_q),
        .f_new_i   (col_f_new),
        .s1_vld_o  (s1_vld),
        .s2_vld_o  (s2_vld),
        .s2_addr_o (s2_addr),
        .s2_data_o (s2_data)
    );

    assign busy      = (state_q != IDLE);
    assign step_cnt  = step_q;
    assign rd_addr   = addr_q;
    assign col_omega = omega_q;
    assign col_f     = s1_vld ? rd_data : '0;
    assign wr_en     = s2_vld & ~hold;
    assign wr_addr   = s2_addr;
    assign wr_data   = s2_data;

`ifdef COLLIDE_MASS_MON_EN
    logic        run_entry;
    logic [31:0] mass_q;

    assign run_entry = (state_q != RUN) && (state_d == RUN);

    // Accumulate sign-extended rho of each stage-1 cell; cleared on RUN entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mass_q <= '0;
        end else if (run_entry) begin
            mass_q <= '0;
        end else if (s1_vld && !hold) begin
            mass_q <= mass_q + {{(32-WORD_W){col_rho[WORD_W-1]}}, col_rho};
        end
    end

    assign mass_sum = mass_q;
`else
    logic unused_rho;
    assign unused_rho = ^col_rho;
`endif

endmodule
